fp_mult_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier with a valid/ready handshake. It succeeds the combinational 32-bit multiplier. It adds configurable exponent and mantissa widths, round-to-nearest-even, special-value handling, status flags and back-pressure. It sits between operand-issue logic and any result consumer in the floating-point arithmetic datapath.

---
 rtl/fp_mult_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_pipe
// Brief    : Three-stage pipelined IEEE-754-style multiplier with valid/ready
//            handshake, round-to-nearest-even and special-value handling.
// Revision : 1.0
// ============================================================================
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   num1,
  input  logic [EXP_W+MAN_W:0]   num2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   product,
  output logic                   flag_ovf,
  output logic                   flag_unf,
  output logic                   flag_inv
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;

  localparam logic signed [EW-1:0] BIAS_S  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_S   = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S  = '0;

  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } special_e;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- stage 1
  logic                 s1_valid_q,   s1_valid_d;
  logic                 s1_sign_q,    s1_sign_d;
  logic signed [EW-1:0] s1_exp_q,     s1_exp_d;
  logic [PW-1:0]        s1_mant_q,    s1_mant_d;
  special_e             s1_special_q, s1_special_d;

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

  always_comb begin
    sign_a = num1[W-1];
    sign_b = num2[W-1];
    exp_a  = num1[W-2:MAN_W];
    exp_b  = num2[W-2:MAN_W];
    frac_a = num1[MAN_W-1:0];
    frac_b = num2[MAN_W-1:0];

    // Subnormals have exp==0 and are deliberately folded into zero.
    a_nan  = (&exp_a) && (|frac_a);
    a_inf  = (&exp_a) && !(|frac_a);
    a_zero = (exp_a == '0);
    b_nan  = (&exp_b) && (|frac_b);
    b_inf  = (&exp_b) && !(|frac_b);
    b_zero = (exp_b == '0);

    s1_valid_d = in_valid;
    s1_sign_d  = sign_a ^ sign_b;
    s1_exp_d   = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
    s1_mant_d  = PW'({1'b1, frac_a}) * PW'({1'b1, frac_b});

    s1_special_d = SP_NONE;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      s1_special_d = SP_NAN;
    end else if (a_inf || b_inf) begin
      s1_special_d = SP_INF;
    end else if (a_zero || b_zero) begin
      s1_special_d = SP_ZERO;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic                 s2_valid_q,   s2_valid_d;
  logic                 s2_sign_q,    s2_sign_d;
  logic signed [EW-1:0] s2_exp_q,     s2_exp_d;
  logic [MAN_W-1:0]     s2_frac_q,    s2_frac_d;
  logic                 s2_guard_q,   s2_guard_d;
  logic                 s2_sticky_q,  s2_sticky_d;
  special_e             s2_special_q, s2_special_d;

  always_comb begin
    s2_valid_d   = s1_valid_q;
    s2_sign_d    = s1_sign_q;
    s2_special_d = s1_special_q;
    if (s1_mant_q[PW-1]) begin
      s2_frac_d   = s1_mant_q[PW-2 -: MAN_W];
      s2_guard_d  = s1_mant_q[MAN_W];
      s2_sticky_d = |s1_mant_q[MAN_W-1:0];
      s2_exp_d    = s1_exp_q + ONE_S;
    end else begin
      s2_frac_d   = s1_mant_q[PW-3 -: MAN_W];
      s2_guard_d  = s1_mant_q[MAN_W-1];
      s2_sticky_d = |s1_mant_q[MAN_W-2:0];
      s2_exp_d    = s1_exp_q;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] product_q,   product_d;
  logic         ovf_q,       ovf_d;
  logic         unf_q,       unf_d;
  logic         inv_q,       inv_d;

  logic                 rnd_inc;
  logic [MAN_W:0]       rnd_sum;
  logic signed [EW-1:0] exp_r;

  always_comb begin
    rnd_inc = s2_guard_q && (s2_sticky_q || s2_frac_q[0]);
    rnd_sum = {1'b0, s2_frac_q} + (MAN_W + 1)'(rnd_inc);
    // On carry-out the fraction field is already all zeros; only bump exp.
    exp_r   = s2_exp_q + (rnd_sum[MAN_W] ? ONE_S : ZERO_S);

    out_valid_d = s2_valid_q;
    product_d   = '0;
    ovf_d       = 1'b0;
    unf_d       = 1'b0;
    inv_d       = 1'b0;

    case (s2_special_q)
      SP_NAN: begin
        product_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        inv_d     = 1'b1;
      end
      SP_INF:  product_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SP_ZERO: product_d = {s2_sign_q, {(W-1){1'b0}}};
      default: begin
        if (exp_r >= EXP_MAX) begin
          product_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d     = 1'b1;
        end else if (exp_r <= ZERO_S) begin
          product_d = {s2_sign_q, {(W-1){1'b0}}};
          unf_d     = 1'b1;
        end else begin
          product_d = {s2_sign_q, exp_r[EXP_W-1:0], rnd_sum[MAN_W-1:0]};
        end
      end
    endcase
  end

  // ---------------------------------------------------------- pipe register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_mant_q    <= '0;
      s1_special_q <= SP_NONE;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_exp_q     <= '0;
      s2_frac_q    <= '0;
      s2_guard_q   <= 1'b0;
      s2_sticky_q  <= 1'b0;
      s2_special_q <= SP_NONE;
      out_valid_q  <= 1'b0;
      product_q    <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      inv_q        <= 1'b0;
    end else if (adv) begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_mant_q    <= s1_mant_d;
      s1_special_q <= s1_special_d;
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_exp_q     <= s2_exp_d;
      s2_frac_q    <= s2_frac_d;
      s2_guard_q   <= s2_guard_d;
      s2_sticky_q  <= s2_sticky_d;
      s2_special_q <= s2_special_d;
      out_valid_q  <= out_valid_d;
      product_q    <= product_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      inv_q        <= inv_d;
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;
  assign flag_inv  = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mult_pipe
// Brief    : Directed self-checking bench for fp_mult_pipe (binary32 and a
//            5/10 half-precision instance).
// Revision : 1.0
// ============================================================================
module tb_fp_mult_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] num1, num2, product;
  logic        flag_ovf, flag_unf, flag_inv;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [15:0] num1_2, num2_2, product2;
  logic        flag_ovf2, flag_unf2, flag_inv2;

  int total = 0;
  int bad   = 0;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inv  (flag_inv)
  );

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .num1      (num1_2),
    .num2      (num2_2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .product   (product2),
    .flag_ovf  (flag_ovf2),
    .flag_unf  (flag_unf2),
    .flag_inv  (flag_inv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One isolated transaction: accepted at the next edge, result visible
  // after the third edge counting the accepting one.
  task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_p, input logic [2:0] exp_f);
    in_valid  = 1'b1;
    num1      = a;
    num2      = b;
    out_ready = 1'b1;
    #1;
    check({tag, "_inready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_prod"},  product, exp_p);
    check({tag, "_flags"}, {29'd0, flag_ovf, flag_unf, flag_inv}, {29'd0, exp_f});
    @(posedge clk); #1;
  endtask

  int   sent, recv, nstall;
  logic acc, dlv, prev_stall, seen;
  logic [31:0] prev_prod;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; num1 = '0; num2 = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; num1_2 = '0; num2_2 = '0; out_ready2 = 1'b1;

    #12;
    check("rst_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_prod",   product, 32'd0);
    check("rst_flags",  {29'd0, flag_ovf, flag_unf, flag_inv}, 32'd0);
    check("rst_inready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // flags encoded {ovf, unf, inv}
    run1("basic",   32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
    run1("neg",     32'hC0000000, 32'h3F000000, 32'hBF800000, 3'b000);
    run1("rne_tie", 32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b000);
    run1("rne_dn",  32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
    run1("ovf",     32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100);
    run1("unf",     32'h00800000, 32'h3F000000, 32'h00000000, 3'b010);
    run1("infzero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001);
    run1("neginf",  32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
    run1("nan",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001);
    run1("subn",    32'h00000001, 32'h3F800000, 32'h00000000, 3'b000);

    // Back-pressure: 8 items of 2^k * 3.0, consumer stalls for 4 cycles.
    sent = 0; recv = 0; nstall = 0; prev_stall = 1'b0; prev_prod = '0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (sent < 8);
      num1      = 32'h3F800000 + (sent << 23);
      num2      = 32'h40400000;
      out_ready = !(c >= 5 && c < 9);
      #1;
      if (prev_stall) check("bp_hold", product, prev_prod);
      if (out_valid && !out_ready) begin
        nstall++;
        check("bp_inready", {31'd0, in_ready}, 32'd0);
      end
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) check("bp_order", product, 32'h40400000 + (recv << 23));
      prev_stall = out_valid && !out_ready;
      prev_prod  = product;
      @(posedge clk); #1;
      if (acc) sent++;
      if (dlv) recv++;
    end
    in_valid = 1'b0;
    check("bp_stalls", nstall, 32'd4);
    check("bp_sent",   sent,   32'd8);
    check("bp_recv",   recv,   32'd8);
    check("bp_drain",  {31'd0, out_valid}, 32'd0);

    // Reset with three items in flight.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; num1 = 32'h3FC00000; num2 = 32'h40000000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("rstmid_pre", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_prod",  product, 32'd0);
    check("rstmid_flags", {29'd0, flag_ovf, flag_unf, flag_inv}, 32'd0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rstmid_stale",   {31'd0, seen}, 32'd0);
    check("rstmid_inready", {31'd0, in_ready}, 32'd1);

    // Half-precision instance: 1.5 * 2.0 = 3.0
    in_valid2 = 1'b1; num1_2 = 16'h3E00; num2_2 = 16'h4000;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("half_valid", {31'd0, out_valid2}, 32'd1);
    check("half_prod",  {16'd0, product2}, 32'h00004200);
    check("half_flags", {29'd0, flag_ovf2, flag_unf2, flag_inv2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
